// File: rtl/snap_pkg.sv
// -----------------------------------------------------------------------------
// snap_pkg
// Shared constants and types for the RAM snapshot block (ram_snapshot and
// snap_bank).
//   SNAP_DEPTH   : number of words captured per snapshot
//   SNAP_LAST    : index of the final word of a snapshot walk
//   SNAP_SUM_W   : width of the wrapping checksum
//   DISP_LIMIT   : first display slot number that lies outside the buffer
//   snap_state_t : copy controller states
// -----------------------------------------------------------------------------
package snap_pkg;

    localparam int          SNAP_DEPTH = 32;
    localparam logic [4:0]  SNAP_LAST  = 5'd31;
    localparam int          SNAP_SUM_W = 32;
    localparam logic [5:0]  DISP_LIMIT = 6'd32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_COPY = 1'b1
    } snap_state_t;

endpackage : snap_pkg

// File: rtl/snap_bank.sv
// -----------------------------------------------------------------------------
// snap_bank
// One snapshot buffer: 2**ADDR_W x DATA_W storage with a synchronous write
// port and a registered read port.
// Ports:
//   clk    in   system clock
//   resetn in   asynchronous active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled every clock
//   rdata  out  registered read data (old contents on a same-address write)
// -----------------------------------------------------------------------------
module snap_bank #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset so it maps onto RAM/LUT-RAM; only
    // the read register, which is a visible output, is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule : snap_bank

// File: rtl/ram_snapshot.sv
// -----------------------------------------------------------------------------
// ram_snapshot
// Copies all 2**ADDR_W words of the sorting core's data RAM into a local
// buffer after a sort completes (rising edge of sort_over) or on a manual
// capture request, and serves that buffer to the LCD display stage with a
// 1-cycle registered read. A wrapping checksum and a saturating count of
// completed snapshots are kept alongside.
//
// Build option: define SNAP_DBUF_EN for two banks (copy into the back bank,
// swap on completion) so the display always reads a complete snapshot.
// Without it a single bank is used and disp_hit is suppressed while copying.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   sort_over  in   sort-complete level; rising edge triggers a capture
//   cap_req    in   single-cycle manual capture request
//   src_addr   out  registered read address to the core's debug RAM port
//   src_data   in   combinational read data for src_addr
//   disp_addr  in   display slot number 0..63
//   disp_data  out  snapshot word for disp_addr, 1 cycle later (0 if >= 32)
//   disp_hit   out  slot in range and snapshot valid when sampled
//   busy       out  high while copying
//   snap_valid out  a complete snapshot is readable
//   snap_sum   out  mod-2^DATA_W sum of the last completed snapshot
//   snap_cnt   out  completed snapshots, saturating
// -----------------------------------------------------------------------------
module ram_snapshot
    import snap_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sort_over,
    input  logic              cap_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic [5:0]        disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_hit,
    output logic              busy,
    output logic              snap_valid,
    output logic [DATA_W-1:0] snap_sum,
    output logic [CNT_W-1:0]  snap_cnt
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(SNAP_LAST);

    snap_state_t       state;
    logic              sort_over_q;
    logic              pending;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] acc;

    logic              trig;
    logic              copy_we;
    logic              rd_in_range;
    logic              rd_range_q;
    logic [DATA_W-1:0] bank_rdata;

    assign trig        = (sort_over & ~sort_over_q) | cap_req;
    assign copy_we     = (state == S_COPY);
    assign rd_in_range = (disp_addr < DISP_LIMIT);

`ifdef SNAP_DBUF_EN
    // front selects the bank the display reads; the copy writes the other.
    logic              front;
    logic              rd_sel_q;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
`endif

    // -------------------------------------------------------------------------
    // Copy controller
    // -------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge value of every other (acc + src_data below
    // relies on that).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            sort_over_q <= 1'b0;
            pending     <= 1'b0;
            idx         <= '0;
            src_addr    <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            snap_valid  <= 1'b0;
            snap_sum    <= '0;
            snap_cnt    <= '0;
`ifdef SNAP_DBUF_EN
            front       <= 1'b0;
`endif
        end else begin
            sort_over_q <= sort_over;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state    <= S_COPY;
                        idx      <= '0;
                        src_addr <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_COPY: begin
                    // src_addr tracks idx, so src_data is the word for idx.
                    idx      <= idx + 1'b1;
                    src_addr <= src_addr + 1'b1;
                    acc      <= acc + src_data;
`ifndef SNAP_DBUF_EN
                    // The only bank is being overwritten from here on.
                    if (idx == '0) begin
                        snap_valid <= 1'b0;
                    end
`endif
                    if (idx == IDX_LAST) begin
                        snap_sum   <= acc + src_data;
                        snap_valid <= 1'b1;
                        if (snap_cnt != '1) begin
                            snap_cnt <= snap_cnt + 1'b1;
                        end
`ifdef SNAP_DBUF_EN
                        front <= ~front;
`endif
                        // A trigger on the completion edge counts as pending;
                        // idx and src_addr wrap to 0 on their own.
                        if (pending || trig) begin
                            pending <= 1'b0;
                            acc     <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (trig) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Display read side
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_hit   <= 1'b0;
            rd_range_q <= 1'b0;
`ifdef SNAP_DBUF_EN
            rd_sel_q   <= 1'b0;
`endif
        end else begin
            rd_range_q <= rd_in_range;
`ifdef SNAP_DBUF_EN
            rd_sel_q   <= front;
            disp_hit   <= rd_in_range & snap_valid;
`else
            disp_hit   <= rd_in_range & snap_valid & ~busy;
`endif
        end
    end

`ifdef SNAP_DBUF_EN
    snap_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk    (clk),
        .resetn (resetn),
        .we     (copy_we & front),
        .waddr  (idx),
        .wdata  (src_data),
        .raddr  (disp_addr[ADDR_W-1:0]),
        .rdata  (rdata0)
    );

    snap_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk    (clk),
        .resetn (resetn),
        .we     (copy_we & ~front),
        .waddr  (idx),
        .wdata  (src_data),
        .raddr  (disp_addr[ADDR_W-1:0]),
        .rdata  (rdata1)
    );

    // Select with the bank choice captured alongside the read address, so a
    // swap on the same edge cannot mix banks.
    assign bank_rdata = rd_sel_q ? rdata1 : rdata0;
`else
    snap_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
        .clk    (clk),
        .resetn (resetn),
        .we     (copy_we),
        .waddr  (idx),
        .wdata  (src_data),
        .raddr  (disp_addr[ADDR_W-1:0]),
        .rdata  (bank_rdata)
    );
`endif

    // NOTE: combinational outputs get a default on every path so no latch is
    // inferred.
    always_comb begin
        disp_data = '0;
        if (rd_range_q) begin
            disp_data = bank_rdata;
        end
    end

endmodule : ram_snapshot

// File: doc/ram_snapshot.md
Name: ram_snapshot

Overview:
- Sits between the sorting CPU core's debug RAM read port and the LCD display stage.
- After a sort completes, or on request, it walks all 32 data-RAM words and copies them into a local buffer.
- The display reads a stable, coherent image from that buffer, with a 1-cycle registered read keyed on the display slot number.
- It also produces a wrapping 32-bit checksum of each snapshot, for on-screen or bench verification.

Parameters:
- ADDR_W, 5: source RAM address width. Depth = 2**ADDR_W = 32 words.
- DATA_W, 32: word width.
- CNT_W, 8: width of the saturating snapshot counter.

Ports:
- clk  in  1  system clock (10 MHz board clock).
- resetn  in  1  asynchronous active-low reset.
- sort_over  in  1  level from the CPU core. A rising edge triggers a capture.
- cap_req  in  1  single-cycle manual capture request.
- src_addr  out  ADDR_W  registered read address to the core's debug RAM port.
- src_data  in  DATA_W  combinational read data for src_addr.
- disp_addr  in  6  display slot number, range 0..63.
- disp_data  out  DATA_W  registered snapshot word for disp_addr.
- disp_hit  out  1  registered. Set when disp_addr < 32 and snap_valid was set in the sampling cycle.
- busy  out  1  high while copying.
- snap_valid  out  1  at least one complete snapshot is readable.
- snap_sum  out  DATA_W  mod-2^32 sum of all words in the last completed snapshot.
- snap_cnt  out  CNT_W  completed snapshots, saturating at 255.

Behaviour:
- Reset values: src_addr=0, disp_data=0, disp_hit=0, busy=0, snap_valid=0, snap_sum=0, snap_cnt=0. Internal state: sort_over_q=0, pending=0, idx=0, acc=0.
- Buffer contents are not reset.
- Trigger (trig) = (sort_over & ~sort_over_q) | cap_req. sort_over_q is sort_over delayed by one clk.
- FSM has two states, IDLE and COPY.
  - IDLE, trig: go to COPY next cycle. idx=0, src_addr=0, acc=0, busy=1.
  - COPY, every cycle:
    - buf[idx] <= src_data; acc <= acc + src_data.
    - idx and src_addr advance by 1, wrapping at 31.
    - src_data is sampled on the edge that ends the cycle in which src_addr=idx.
  - COPY, idx==31: write the final word, then update snap_sum = acc + src_data and snap_cnt++ (saturating at 255).
    - Set snap_valid=1.
    - If pending is set: clear pending and re-enter COPY at idx=0. busy stays high.
    - Otherwise return to IDLE with busy=0.
  - Copy latency is exactly 32 cycles from the first COPY cycle to busy falling.
- trig during COPY sets pending. pending holds at most one request; further triggers are absorbed.
- trig in the same cycle as the idx==31 completion counts as pending and causes an immediate restart.
- Display read: disp_data <= buf[disp_addr[4:0]] when disp_addr<32, else 0. Latency is 1 cycle.
- disp_addr >= 32 forces disp_hit=0 and disp_data=0.
- A reset asserted mid-COPY aborts the copy immediately. All outputs return to reset values and the partial copy is discarded (snap_valid=0).
- Checksum arithmetic wraps modulo 2^32. Carries are discarded.

Optional Feature:
- Macro: SNAP_DBUF_EN.
- Defined:
  - Two banks. COPY writes the back bank while the display reads the front bank.
  - On completion the banks swap, on the same edge that updates snap_sum.
  - snap_valid stays 1 during later copies.
  - The display never sees a mixed snapshot.
- Undefined:
  - A single bank is used.
  - snap_valid is cleared on the first COPY cycle and set again on completion.
  - disp_hit is 0 while busy. disp_data is still driven and may show a partial image.

Decomposition:
- Package snap_pkg holds:
  - Constants SNAP_DEPTH=32 and SNAP_LAST=5'd31.
  - Enum snap_state_t {S_IDLE, S_COPY}.
  - The checksum width and the display slot range limit (6'd32).
- Sub-module snap_bank:
  - 32xDATA_W storage.
  - One synchronous write port (we, waddr, wdata).
  - One registered read port (raddr, rdata).
  - Instantiated once, or twice under SNAP_DBUF_EN, with bank-select muxing in ram_snapshot.

Test Plan:
1. Model RAM with word[i]=i+1; pulse cap_req.
   - busy is high for exactly 32 cycles.
   - snap_sum=528 (0x210), snap_cnt=1, snap_valid=1.
   - disp_addr=5 gives disp_data=6 and disp_hit=1 one cycle later.
2. sort_over held high for 100 cycles after reset.
   - Exactly one capture occurs; snap_cnt=1.
   - Raise it again after dropping: snap_cnt=2.
3. cap_req at COPY cycle 10, then three more pulses during the same copy.
   - Exactly one restart occurs.
   - busy is continuously high for 64 cycles; snap_cnt increases by 2.
4. Words set to 0xFFFFFFFF.
   - snap_sum = 32*(2^32-1) mod 2^32 = 0xFFFFFFE0.
5. resetn low at COPY cycle 17.
   - All outputs are 0 immediately (asynchronous).
   - After release, snap_valid=0 until a new full copy completes.
6. disp_addr sweep 30..40.
   - Slots 30 and 31 return data with hit=1.
   - Slots 32..40 return 0 with hit=0.
   - Under SNAP_DBUF_EN, while a copy of new values runs, reads return only the old snapshot until the swap.
